// File: rtl/mem_port_scheduler.sv
// Arbitrates the shared instruction/data memory port between fetch and load/store, data first.
// Optional wait-cycle watchdog with bus_err reporting is enabled by defining MEM_TIMEOUT_EN.
module mem_port_scheduler #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_be,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic        stall_pc,
    output logic        bus_err,
    output logic        to_mem_req,
    output logic        to_mem_rw_mode,
    output logic [31:0] to_mem_addr,
    output logic [31:0] to_mem_write_data,
    output logic [3:0]  to_mem_byte_en,
    input  logic        mem_ready,
    input  logic [31:0] from_mem_data,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t state;
    logic   drop;
    logic   drop_now;
    logic   expire;

    assign fsm_state = state;
    assign stall_pc  = (ls_req & ~ls_done) | (state == DATA);
    // A flush in the completing cycle still suppresses the result.
    assign drop_now  = drop | ((state == FETCH) & if_flush);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] wait_cnt;

    assign expire = (state != IDLE) & ~mem_ready & (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            bus_err <= expire & ~((state == FETCH) & drop_now);
            if (state == IDLE) begin
                wait_cnt <= '0;
            end else if (!mem_ready) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign expire  = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= IDLE;
            drop              <= 1'b0;
            if_done           <= 1'b0;
            if_rdata          <= '0;
            ls_done           <= 1'b0;
            ls_rdata          <= '0;
            to_mem_req        <= 1'b0;
            to_mem_rw_mode    <= 1'b1;
            to_mem_addr       <= '0;
            to_mem_write_data <= '0;
            to_mem_byte_en    <= '0;
        end else begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
            case (state)
                IDLE: begin
                    // Done qualifiers keep a requester that still holds req from being re-served.
                    if (ls_req && !ls_done) begin
                        state             <= DATA;
                        to_mem_req        <= 1'b1;
                        to_mem_rw_mode    <= ~ls_we;
                        to_mem_addr       <= ls_addr;
                        to_mem_write_data <= ls_we ? ls_wdata : 32'h0;
                        to_mem_byte_en    <= ls_we ? ls_be : 4'b0000;
                    end else if (if_req && !if_done) begin
                        state             <= FETCH;
                        to_mem_req        <= 1'b1;
                        to_mem_rw_mode    <= 1'b1;
                        to_mem_addr       <= if_addr;
                        to_mem_write_data <= '0;
                        to_mem_byte_en    <= '0;
                    end
                end
                FETCH: begin
                    if (mem_ready || expire) begin
                        state      <= IDLE;
                        to_mem_req <= 1'b0;
                        drop       <= 1'b0;
                        if (!drop_now) begin
                            if_done  <= 1'b1;
                            if_rdata <= mem_ready ? from_mem_data : 32'h0;
                        end
                    end else if (if_flush) begin
                        drop <= 1'b1;
                    end
                end
                DATA: begin
                    if (mem_ready || expire) begin
                        state      <= IDLE;
                        to_mem_req <= 1'b0;
                        ls_done    <= 1'b1;
                        ls_rdata   <= (mem_ready && to_mem_rw_mode) ? from_mem_data : 32'h0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed bench for mem_port_scheduler: reset, fetch, arbitration, flush, load, stalled memory.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_mem_port_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_be;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        stall_pc;
    logic        bus_err;
    logic        to_mem_req;
    logic        to_mem_rw_mode;
    logic [31:0] to_mem_addr;
    logic [31:0] to_mem_write_data;
    logic [3:0]  to_mem_byte_en;
    logic        mem_ready;
    logic [31:0] from_mem_data;
    logic [1:0]  fsm_state;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    mem_port_scheduler #(.TIMEOUT_CYCLES(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .if_req            (if_req),
        .if_addr           (if_addr),
        .if_flush          (if_flush),
        .if_done           (if_done),
        .if_rdata          (if_rdata),
        .ls_req            (ls_req),
        .ls_we             (ls_we),
        .ls_addr           (ls_addr),
        .ls_wdata          (ls_wdata),
        .ls_be             (ls_be),
        .ls_done           (ls_done),
        .ls_rdata          (ls_rdata),
        .stall_pc          (stall_pc),
        .bus_err           (bus_err),
        .to_mem_req        (to_mem_req),
        .to_mem_rw_mode    (to_mem_rw_mode),
        .to_mem_addr       (to_mem_addr),
        .to_mem_write_data (to_mem_write_data),
        .to_mem_byte_en    (to_mem_byte_en),
        .mem_ready         (mem_ready),
        .from_mem_data     (from_mem_data),
        .fsm_state         (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int seen_done;
        int req_cycles;

        // ---------------- reset with random inputs ----------------
        rst_n = 1'b0;
        repeat (3) begin
            if_req        = 1'($urandom_range(0, 1));
            if_addr       = $urandom;
            if_flush      = 1'($urandom_range(0, 1));
            ls_req        = 1'($urandom_range(0, 1));
            ls_we         = 1'($urandom_range(0, 1));
            ls_addr       = $urandom;
            ls_wdata      = $urandom;
            ls_be         = 4'($urandom_range(0, 15));
            mem_ready     = 1'($urandom_range(0, 1));
            from_mem_data = $urandom;
            step();
        end
        if_req = 0; if_flush = 0; ls_req = 0; ls_we = 0; mem_ready = 0;
        if_addr = 0; ls_addr = 0; ls_wdata = 0; ls_be = 0; from_mem_data = 0;
        #1;
        check("rst_state", 32'(fsm_state), 32'd0);
        check("rst_req", 32'(to_mem_req), 32'd0);
        check("rst_rw", 32'(to_mem_rw_mode), 32'd1);
        check("rst_addr", to_mem_addr, 32'h0);
        check("rst_wdata", to_mem_write_data, 32'h0);
        check("rst_be", 32'(to_mem_byte_en), 32'h0);
        check("rst_dones", {30'd0, if_done, ls_done}, 32'd0);
        check("rst_rdata", if_rdata | ls_rdata, 32'h0);
        check("rst_stall_err", {30'd0, stall_pc, bus_err}, 32'd0);
        step();
        rst_n = 1'b1;

        // ---------------- zero-wait fetch ----------------
        step();
        if_req = 1; if_addr = 32'h100;
        step();
        check("zf_req", 32'(to_mem_req), 32'd1);
        check("zf_addr", to_mem_addr, 32'h100);
        check("zf_rw_be", {27'd0, to_mem_rw_mode, to_mem_byte_en}, {27'd0, 1'b1, 4'h0});
        check("zf_state", 32'(fsm_state), 32'd1);
        mem_ready = 1; from_mem_data = 32'h00500093;
        step();
        check("zf_done", 32'(if_done), 32'd1);
        check("zf_rdata", if_rdata, 32'h00500093);
        check("zf_req_clr", 32'(to_mem_req), 32'd0);
        mem_ready = 0; if_req = 0;
        step();
        check("zf_done_pulse", 32'(if_done), 32'd0);
        check("zf_idle", 32'(fsm_state), 32'd0);

        // ---------------- simultaneous store + fetch, 2 wait states ----------------
        ls_req = 1; ls_we = 1; ls_addr = 32'h2004; ls_wdata = 32'hDEADBEEF; ls_be = 4'hF;
        if_req = 1; if_addr = 32'h104;
        #1;
        check("sim_stall_req", 32'(stall_pc), 32'd1);
        step();
        check("sim_state", 32'(fsm_state), 32'd2);
        check("sim_req", 32'(to_mem_req), 32'd1);
        check("sim_rw", 32'(to_mem_rw_mode), 32'd0);
        check("sim_addr", to_mem_addr, 32'h2004);
        check("sim_wdata", to_mem_write_data, 32'hDEADBEEF);
        check("sim_be", 32'(to_mem_byte_en), 32'hF);
        step();
        ls_addr = 32'h9999; ls_wdata = 32'h1;
        #1;
        check("sim_hold_addr", to_mem_addr, 32'h2004);
        check("sim_hold_wdata", to_mem_write_data, 32'hDEADBEEF);
        check("sim_stall_wait", 32'(stall_pc), 32'd1);
        step();
        mem_ready = 1; from_mem_data = 32'hAAAAAAAA;
        step();
        check("sim_ls_done", {30'd0, ls_done, if_done}, {30'd0, 1'b1, 1'b0});
        check("sim_ls_rdata", ls_rdata, 32'h0);
        check("sim_stall_clr", 32'(stall_pc), 32'd0);
        mem_ready = 0; ls_req = 0; ls_we = 0;
        step();
        check("sim_f_state", 32'(fsm_state), 32'd1);
        check("sim_f_addr", to_mem_addr, 32'h104);
        check("sim_f_rw_be", {27'd0, to_mem_rw_mode, to_mem_byte_en}, {27'd0, 1'b1, 4'h0});
        check("sim_f_wdata", to_mem_write_data, 32'h0);
        mem_ready = 1; from_mem_data = 32'h00000013;
        step();
        check("sim_f_done", 32'(if_done), 32'd1);
        check("sim_f_rdata", if_rdata, 32'h00000013);
        mem_ready = 0; if_req = 0;
        step();

        // ---------------- flush during a 3-wait-state fetch ----------------
        if_req = 1; if_addr = 32'h108;
        step();
        check("fl_state", 32'(fsm_state), 32'd1);
        step();
        if_flush = 1;
        step();
        if_flush = 0;
        step();
        mem_ready = 1; from_mem_data = 32'hBADBAD00;
        step();
        check("fl_no_done", 32'(if_done), 32'd0);
        check("fl_rdata_keep", if_rdata, 32'h00000013);
        check("fl_idle", {30'd0, fsm_state}, 32'd0);
        mem_ready = 0; if_req = 0;
        step();
        if_req = 1; if_addr = 32'h200;
        step();
        check("fl_next_addr", to_mem_addr, 32'h200);
        mem_ready = 1; from_mem_data = 32'h11111111;
        step();
        check("fl_next_done", 32'(if_done), 32'd1);
        check("fl_next_rdata", if_rdata, 32'h11111111);
        mem_ready = 0; if_req = 0;
        step();

        // ---------------- load with 1 wait state ----------------
        ls_req = 1; ls_we = 0; ls_addr = 32'h3000; ls_be = 4'hF; ls_wdata = 32'h55555555;
        step();
        check("ld_rw", 32'(to_mem_rw_mode), 32'd1);
        check("ld_be", 32'(to_mem_byte_en), 32'h0);
        check("ld_wdata", to_mem_write_data, 32'h0);
        check("ld_addr", to_mem_addr, 32'h3000);
        step();
        mem_ready = 1; from_mem_data = 32'h12345678;
        step();
        check("ld_done", 32'(ls_done), 32'd1);
        check("ld_rdata", ls_rdata, 32'h12345678);
        check("ld_no_err", 32'(bus_err), 32'd0);
        mem_ready = 0; ls_req = 0;
        step();

        // ---------------- memory never ready ----------------
        ls_req = 1; ls_we = 0; ls_addr = 32'h4000;
        seen_done  = 0;
        req_cycles = 0;
`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < 20 && seen_done == 0; i++) begin
            step();
            if (to_mem_req) req_cycles++;
            if (ls_done) begin
                seen_done = 1;
                check("to_err", 32'(bus_err), 32'd1);
                check("to_rdata", ls_rdata, 32'h0);
            end
        end
        check("to_seen_done", 32'(seen_done), 32'd1);
        check("to_req_cycles", 32'(req_cycles), 32'd5);
        ls_req = 0;
        step();
`else
        for (int i = 0; i < 100; i++) begin
            step();
            if (ls_done || bus_err) seen_done++;
            if (to_mem_req) req_cycles++;
        end
        check("nt_no_done", 32'(seen_done), 32'd0);
        check("nt_req_held", 32'(req_cycles), 32'd100);
        // Reset in the middle of the stalled access abandons it.
        rst_n = 0;
        step();
        check("mr_req", 32'(to_mem_req), 32'd0);
        check("mr_state", 32'(fsm_state), 32'd0);
        ls_req = 0;
        rst_n = 1;
        step();
        check("mr_no_done", 32'(ls_done), 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
